crc_a_sequencer: RTL and testbench

CRC_A_SEQUENCER -- requirements
Module: crc_a_sequencer

---
 rtl/iso14443a_pkg.sv | 29 ++
 rtl/crc_a.sv | 23 ++
 rtl/crc_a_sequencer.sv | 144 ++++++++++++++
 tb/tb_crc_a_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/iso14443a_pkg.sv
// ISO 14443-A shared types: sequencer state encoding and CRC-A constants/step function.
// APPEND states exist only when CRC_A_SEQ_TX_APPEND_EN is defined.
package iso14443a_pkg;

    localparam logic [15:0] CRC_A_PRESET  = 16'h6363;
    localparam logic [15:0] CRC_A_RESIDUE = 16'h0000;
    localparam logic [15:0] CRC_A_POLY    = 16'h8408;  // x^16+x^12+x^5+1, bit-reversed

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        SHIFT,
        GAP,
        CHECK
`ifdef CRC_A_SEQ_TX_APPEND_EN
        ,
        APPEND_LO,
        APPEND_HI
`endif
    } seq_state_t;

    function automatic logic [15:0] crc_a_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        crc_a_step = (c >> 1) ^ (fb ? CRC_A_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc_a.sv
// Bit-serial CRC-A (LSb first): start presets the register, sample folds in one data bit.
// Latency: crc reflects a sample on the following cycle; no backpressure.
module crc_a (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sample,
    input  logic        data,
    output logic [15:0] crc
);
    import iso14443a_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_A_PRESET;
        end else if (start) begin
            crc <= CRC_A_PRESET;
        end else if (sample) begin
            crc <= crc_a_step(crc, data);
        end
    end

endmodule

// File: rtl/crc_a_sequencer.sv
// Feeds frame bytes bit-serially into crc_a, then checks the residue (RX) or appends the CRC (TX).
// Latency 1+8*(1+SAMPLE_GAP) cycles/byte; in_ready only in LOAD, CRC bytes held until out_ready.
// TX append path exists only with CRC_A_SEQ_TX_APPEND_EN; otherwise every frame is checked.
module crc_a_sequencer #(
    parameter int SAMPLE_GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done,
    output logic        crc_ok,
    output logic [15:0] crc_value
);
    import iso14443a_pkg::*;

    localparam logic [2:0] GAP_LAST = 3'(SAMPLE_GAP - 1);

    seq_state_t  state, state_nxt, after_bit, frame_end;
    logic [7:0]  byte_r;
    logic        last_r;
    logic [2:0]  bit_cnt, gap_cnt;
    logic [15:0] crc;
    logic        finish, ok_nxt;

    crc_a u_crc_a (
        .clk    (clk),
        .rst_n  (~rst),
        .start  (state == START),
        .sample (state == SHIFT),
        .data   (byte_r[bit_cnt]),
        .crc    (crc)
    );

`ifdef CRC_A_SEQ_TX_APPEND_EN
    logic mode_r;

    assign frame_end = mode_r ? APPEND_LO : CHECK;
    assign finish    = ((state == CHECK) || (state == APPEND_HI && out_ready)) && !abort;
    assign out_valid = (state == APPEND_LO) || (state == APPEND_HI);
    assign out_last  = (state == APPEND_HI);
    assign out_data  = (state == APPEND_LO) ? crc[7:0] :
                       (state == APPEND_HI) ? crc[15:8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mode_r <= mode;
        end
    end
`else
    logic unused_tx_inputs;

    assign unused_tx_inputs = mode ^ out_ready;
    assign frame_end = CHECK;
    assign finish    = (state == CHECK) && !abort;
    assign out_valid = 1'b0;
    assign out_last  = 1'b0;
    assign out_data  = 8'h00;
`endif

    assign in_ready = (state == LOAD);
    assign ok_nxt   = (state == CHECK) ? (crc == CRC_A_RESIDUE) : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        after_bit = SHIFT;
        if (bit_cnt == 3'd7) begin
            after_bit = last_r ? frame_end : LOAD;
        end
        case (state)
            IDLE:      if (in_valid) state_nxt = START;
            START:     state_nxt = LOAD;
            LOAD:      if (in_valid) state_nxt = SHIFT;
            SHIFT:     state_nxt = (SAMPLE_GAP == 0) ? after_bit : GAP;
            GAP:       if (gap_cnt == GAP_LAST) state_nxt = after_bit;
            CHECK:     state_nxt = IDLE;
`ifdef CRC_A_SEQ_TX_APPEND_EN
            APPEND_LO: if (out_ready) state_nxt = APPEND_HI;
            APPEND_HI: if (out_ready) state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
        // Abort wins over any same-cycle handshake; the byte is simply dropped.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_r  <= 8'h00;
            last_r  <= 1'b0;
            bit_cnt <= 3'd0;
            gap_cnt <= 3'd0;
        end else begin
            if (state == LOAD && in_valid) begin
                byte_r  <= in_data;
                last_r  <= in_last;
                bit_cnt <= 3'd0;
            end
            if (state == SHIFT) begin
                gap_cnt <= 3'd0;
                if (SAMPLE_GAP == 0) bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 3'd1;
                if (gap_cnt == GAP_LAST) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_value <= 16'h0000;
        end else begin
            done <= finish;
            if (finish) begin
                crc_ok    <= ok_nxt;
                crc_value <= crc;
            end
        end
    end

endmodule

// File: tb/tb_crc_a_sequencer.sv
// Directed-vector bench for crc_a_sequencer with hand-computed CRC-A values.
module tb_crc_a_sequencer;

    logic        clk = 1'b0;
    logic        rst, mode, in_valid, in_ready, in_last, abort;
    logic        out_valid, out_ready, out_last, done, crc_ok;
    logic [7:0]  in_data, out_data;
    logic [15:0] crc_value;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          hs_cyc[4];
    logic        g_done, g_ok, g_stall_bad;
    logic [15:0] g_val;
    int          g_nout;
    logic [7:0]  g_d[2];
    logic        g_l[2];

    crc_a_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_value (crc_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int idx);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        hs_cyc[idx] = cyc;
    endtask

    task automatic collect(input int stall);
        int         stalled;
        logic [7:0] first;
        g_done = 0; g_nout = 0; g_stall_bad = 0; stalled = 0; first = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                g_done = 1; g_val = crc_value; g_ok = crc_ok;
                break;
            end
            if (out_valid && stalled < stall) begin
                if (stalled == 0) first = out_data;
                else if (out_data !== first) g_stall_bad = 1;
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (g_nout < 2) begin
                        g_d[g_nout] = out_data;
                        g_l[g_nout] = out_last;
                    end
                    g_nout++;
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (!g_done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input int n,
                             input logic md, input int stall);
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        mode = md;
        for (int i = 0; i < n; i++) send_byte(bs[i], i == n - 1, i);
        in_valid = 1'b0;
        in_last  = 1'b0;
        mode     = ~md;
        collect(stall);
    endtask

    task automatic check_tx(input logic [7:0] lo, input logic [7:0] hi);
`ifdef CRC_A_SEQ_TX_APPEND_EN
        chk("tx_nout", g_nout, 2);
        chk("tx_lo", g_d[0], lo);
        chk("tx_lo_last", g_l[0], 0);
        chk("tx_hi", g_d[1], hi);
        chk("tx_hi_last", g_l[1], 1);
        chk("tx_ok", g_ok, 1);
`else
        chk("tx_nout", g_nout, 0);
        chk("tx_ok", g_ok, 0);
`endif
        chk("tx_val", g_val, {hi, lo});
    endtask

    initial begin
        int n_done;
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, out_valid, out_data, out_last, done, crc_ok, crc_value}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 0);
        check_tx(8'hA0, 8'h1E);
        chk("throughput", hs_cyc[1] - hs_cyc[0], 17);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("value_held", crc_value, 16'h1EA0);

        run_frame(8'h12, 8'h34, 8'h00, 8'h00, 2, 1'b1, 0);
        check_tx(8'h26, 8'hCF);

        run_frame(8'h12, 8'h34, 8'h26, 8'hCF, 4, 1'b0, 0);
        chk("rx_good_ok", g_ok, 1);
        chk("rx_good_val", g_val, 16'h0000);

        run_frame(8'h12, 8'h34, 8'h26, 8'hCE, 4, 1'b0, 0);
        chk("rx_bad_ok", g_ok, 0);

        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 10);
        check_tx(8'hA0, 8'h1E);
`ifdef CRC_A_SEQ_TX_APPEND_EN
        chk("stall_hold", g_stall_bad, 0);
`endif

        // Reset in the middle of the first byte's bit stream
        mode = 1'b0;
        send_byte(8'h55, 1'b0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {in_ready, out_valid, out_data, out_last, done, crc_ok, crc_value}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(8'h00, 8'h00, 8'hA0, 8'h1E, 4, 1'b0, 0);
        chk("rx_after_rst_ok", g_ok, 1);
        chk("rx_after_rst_val", g_val, 16'h0000);

        // Abort while bit 3 of the second byte is being sampled
        mode = 1'b1;
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h11, 1'b0, 1);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs", {in_ready, out_valid, done}, 0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_idle_ready", in_ready, 0);
        chk("abort_ok_kept", crc_ok, 1);
        chk("abort_val_kept", crc_value, 16'h0000);
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b1, 0);
        check_tx(8'hA0, 8'h1E);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
